// File: rtl/branch_ctrl_pkg.sv
// Shared types and encodings for the branch resolution controller.
// Holds the FSM state enum, RV32I branch funct3 values and comparator control codes.
package branch_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [3:0] CMP_EQ   = 4'b0000;
    localparam logic [3:0] CMP_NE   = 4'b0001;
    localparam logic [3:0] CMP_LT   = 4'b0010;
    localparam logic [3:0] CMP_GE   = 4'b0011;
    localparam logic [3:0] CMP_LTU  = 4'b0100;
    localparam logic [3:0] CMP_GEU  = 4'b0101;
    // Reserved code: the comparator treats it as never-taken.
    localparam logic [3:0] CMP_NONE = 4'b1111;

    function automatic logic [3:0] f3_to_cmp(input logic [2:0] f3);
        logic [3:0] code;
        code = CMP_NONE;
        case (f3)
            F3_BEQ:  code = CMP_EQ;
            F3_BNE:  code = CMP_NE;
            F3_BLT:  code = CMP_LT;
            F3_BGE:  code = CMP_GE;
            F3_BLTU: code = CMP_LTU;
            F3_BGEU: code = CMP_GEU;
            default: code = CMP_NONE;
        endcase
        return code;
    endfunction

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 != 3'b010) && (f3 != 3'b011);
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch comparator: evaluates the branch condition selected by ctrl.
// Unknown control codes never report taken.
module branch_cmp
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      ctrl,
    output logic            taken
);

    always_comb begin
        taken = 1'b0;
        case (ctrl)
            CMP_EQ:  taken = (a == b);
            CMP_NE:  taken = (a != b);
            CMP_LT:  taken = ($signed(a) <  $signed(b));
            CMP_GE:  taken = ($signed(a) >= $signed(b));
            CMP_LTU: taken = (a <  b);
            CMP_GEU: taken = (a >= b);
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// Branch resolution controller: captures a branch request, evaluates it for one cycle,
// then holds the resolution until the consumer accepts it, flushing on mispredict.
module branch_resolve_ctrl
    import branch_ctrl_pkg::*;
#(
    parameter int unsigned XLEN    = 32,
    parameter int unsigned PC_STEP = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [XLEN-1:0] req_pc,
    input  logic [XLEN-1:0] req_imm,
    input  logic [2:0]      req_funct3,
    input  logic [XLEN-1:0] req_rs1,
    input  logic [XLEN-1:0] req_rs2,
    input  logic            req_pred_taken,
    input  logic            kill,
    output logic            res_valid,
    input  logic            res_ready,
    output logic            res_taken,
    output logic            res_mispredict,
    output logic            res_illegal,
    output logic [XLEN-1:0] res_target,
    output logic            flush,
    output logic [XLEN-1:0] cnt_branches,
    output logic [XLEN-1:0] cnt_mispredict
);

    state_t          state;
    logic [XLEN-1:0] cap_pc;
    logic [XLEN-1:0] cap_imm;
    logic [XLEN-1:0] cap_rs1;
    logic [XLEN-1:0] cap_rs2;
    logic [2:0]      cap_funct3;
    logic            cap_pred;

    logic [3:0]      cmp_ctrl;
    logic            cmp_taken;
    logic            eval_legal;
    logic            eval_taken;
    logic [XLEN-1:0] eval_target;
    logic            handshake;

    branch_cmp #(.XLEN(XLEN)) u_cmp (
        .a     (cap_rs1),
        .b     (cap_rs2),
        .ctrl  (cmp_ctrl),
        .taken (cmp_taken)
    );

    // Evaluation datapath, fed only from captured operands.
    assign cmp_ctrl    = f3_to_cmp(cap_funct3);
    assign eval_legal  = f3_legal(cap_funct3);
    assign eval_taken  = eval_legal & cmp_taken;
    assign eval_target = eval_taken ? (cap_pc + cap_imm) : (cap_pc + XLEN'(PC_STEP));

    // Kill overrides the consumer's acceptance in the same cycle.
    assign handshake = (state == ST_RESP) & res_ready & ~kill;
    assign req_ready = (state == ST_IDLE) & ~kill;
    assign flush     = handshake & res_mispredict;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= ST_IDLE;
            cap_pc         <= '0;
            cap_imm        <= '0;
            cap_rs1        <= '0;
            cap_rs2        <= '0;
            cap_funct3     <= '0;
            cap_pred       <= 1'b0;
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_mispredict <= 1'b0;
            res_illegal    <= 1'b0;
            res_target     <= '0;
            cnt_branches   <= '0;
            cnt_mispredict <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid && !kill) begin
                        cap_pc     <= req_pc;
                        cap_imm    <= req_imm;
                        cap_rs1    <= req_rs1;
                        cap_rs2    <= req_rs2;
                        cap_funct3 <= req_funct3;
                        cap_pred   <= req_pred_taken;
                        state      <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    if (kill) begin
                        state <= ST_IDLE;
                    end else begin
                        res_valid      <= 1'b1;
                        res_taken      <= eval_taken;
                        res_mispredict <= eval_legal & (eval_taken != cap_pred);
                        res_illegal    <= ~eval_legal;
                        res_target     <= eval_target;
                        state          <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (kill || res_ready) begin
                        if (handshake) begin
                            cnt_branches <= cnt_branches + XLEN'(1);
                            if (res_mispredict) begin
                                cnt_mispredict <= cnt_mispredict + XLEN'(1);
                            end
                        end
                        res_valid      <= 1'b0;
                        res_taken      <= 1'b0;
                        res_mispredict <= 1'b0;
                        res_illegal    <= 1'b0;
                        res_target     <= '0;
                        state          <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// Self-checking bench for branch_resolve_ctrl: table-driven branch vectors plus
// hand-written stall, kill and reset sequences.
module tb_branch_resolve_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_pc;
    logic [31:0] req_imm;
    logic [2:0]  req_funct3;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        req_pred_taken;
    logic        kill;
    logic        res_valid;
    logic        res_ready;
    logic        res_taken;
    logic        res_mispredict;
    logic        res_illegal;
    logic [31:0] res_target;
    logic        flush;
    logic [31:0] cnt_branches;
    logic [31:0] cnt_mispredict;

    int total = 0;
    int bad   = 0;
    logic [31:0] exp_br  = 32'd0;
    logic [31:0] exp_mis = 32'd0;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] pc;
        logic [31:0] imm;
        logic        pred;
        logic        taken;
        logic        mis;
        logic        ill;
        logic [31:0] target;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    branch_resolve_ctrl #(.XLEN(32), .PC_STEP(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_ready      (req_ready),
        .req_pc         (req_pc),
        .req_imm        (req_imm),
        .req_funct3     (req_funct3),
        .req_rs1        (req_rs1),
        .req_rs2        (req_rs2),
        .req_pred_taken (req_pred_taken),
        .kill           (kill),
        .res_valid      (res_valid),
        .res_ready      (res_ready),
        .res_taken      (res_taken),
        .res_mispredict (res_mispredict),
        .res_illegal    (res_illegal),
        .res_target     (res_target),
        .flush          (flush),
        .cnt_branches   (cnt_branches),
        .cnt_mispredict (cnt_mispredict)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                                input logic [31:0] pc, input logic [31:0] imm, input logic pred,
                                input logic taken, input logic mis, input logic ill,
                                input logic [31:0] target);
        vec_t v;
        v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.pc = pc; v.imm = imm; v.pred = pred;
        v.taken = taken; v.mis = mis; v.ill = ill; v.target = target;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    // Offer v in IDLE, then advance to the first RESP cycle (N+2).
    task automatic to_resp(input vec_t v);
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_funct3 = v.f3; req_rs1 = v.rs1; req_rs2 = v.rs2;
        req_pc = v.pc; req_imm = v.imm; req_pred_taken = v.pred;
        @(negedge clk);
        req_valid = 1'b0;
        chk("eval_res_valid", 32'(res_valid), 32'd0);
        chk("eval_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
    endtask

    task automatic check_res(input vec_t v);
        chk("res_valid",      32'(res_valid),      32'd1);
        chk("res_taken",      32'(res_taken),      32'(v.taken));
        chk("res_mispredict", 32'(res_mispredict), 32'(v.mis));
        chk("res_illegal",    32'(res_illegal),    32'(v.ill));
        chk("res_target",     res_target,          v.target);
        chk("flush_pre_hs",   32'(flush),          32'd0);
    endtask

    // Accept the resolution and check the flush pulse and counters.
    task automatic handshake(input vec_t v);
        res_ready = 1'b1;
        #1;
        chk("flush_hs", 32'(flush), 32'(v.mis));
        exp_br = exp_br + 32'd1;
        if (v.mis) exp_mis = exp_mis + 32'd1;
        @(negedge clk);
        res_ready = 1'b0;
        chk("post_res_valid",  32'(res_valid),  32'd0);
        chk("post_res_target", res_target,      32'd0);
        chk("post_res_taken",  32'(res_taken),  32'd0);
        chk("post_flush",      32'(flush),      32'd0);
        chk("cnt_branches",    cnt_branches,    exp_br);
        chk("cnt_mispredict",  cnt_mispredict,  exp_mis);
    endtask

    task automatic run_vec(input vec_t v);
        to_resp(v);
        check_res(v);
        handshake(v);
    endtask

    initial begin
        vec_t v;
        logic [31:0] held;

        // funct3, rs1, rs2, pc, imm, pred, taken, mis, ill, target
        vecs[0]  = mk(3'b000, 32'd5,        32'd5, 32'h100,      32'h20,       1'b0, 1'b1, 1'b1, 1'b0, 32'h120);
        vecs[1]  = mk(3'b100, 32'hFFFFFFFF, 32'd1, 32'h200,      32'h40,       1'b1, 1'b1, 1'b0, 1'b0, 32'h240);
        vecs[2]  = mk(3'b110, 32'hFFFFFFFF, 32'd1, 32'h200,      32'h40,       1'b1, 1'b0, 1'b1, 1'b0, 32'h204);
        vecs[3]  = mk(3'b001, 32'd3,        32'd3, 32'h300,      32'h40,       1'b0, 1'b0, 1'b0, 1'b0, 32'h304);
        vecs[4]  = mk(3'b101, 32'h80000000, 32'd0, 32'h400,      32'h10,       1'b0, 1'b0, 1'b0, 1'b0, 32'h404);
        vecs[5]  = mk(3'b111, 32'h80000000, 32'd0, 32'h400,      32'h10,       1'b0, 1'b1, 1'b1, 1'b0, 32'h410);
        vecs[6]  = mk(3'b010, 32'd7,        32'd7, 32'h500,      32'h80,       1'b1, 1'b0, 1'b0, 1'b1, 32'h504);
        vecs[7]  = mk(3'b000, 32'd0,        32'd0, 32'hFFFFFFF0, 32'h20,       1'b1, 1'b1, 1'b0, 1'b0, 32'h10);
        vecs[8]  = mk(3'b011, 32'd1,        32'd2, 32'h700,      32'h8,        1'b0, 1'b0, 1'b0, 1'b1, 32'h704);
        vecs[9]  = mk(3'b100, 32'd5,        32'd5, 32'h600,      32'h20,       1'b1, 1'b0, 1'b1, 1'b0, 32'h604);
        vecs[10] = mk(3'b001, 32'd1,        32'd2, 32'h100,      32'hFFFFFFF0, 1'b1, 1'b1, 1'b0, 1'b0, 32'hF0);

        rst = 1'b1; req_valid = 1'b0; req_pc = '0; req_imm = '0; req_funct3 = '0;
        req_rs1 = '0; req_rs2 = '0; req_pred_taken = 1'b0; kill = 1'b0; res_ready = 1'b0;
        #1;
        chk("rst_req_ready", 32'(req_ready),    32'd1);
        chk("rst_res_valid", 32'(res_valid),    32'd0);
        chk("rst_flush",     32'(flush),        32'd0);
        chk("rst_target",    res_target,        32'd0);
        chk("rst_cnt_br",    cnt_branches,      32'd0);
        chk("rst_cnt_mis",   cnt_mispredict,    32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < NVEC; i++) begin
            run_vec(vecs[i]);
        end

        // Consumer stalls for 5 cycles: resolution holds, no flush, no new request.
        v = vecs[0];
        to_resp(v);
        check_res(v);
        held = res_target;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_res_valid", 32'(res_valid), 32'd1);
            chk("stall_target",    res_target,     held);
            chk("stall_mis",       32'(res_mispredict), 32'd1);
            chk("stall_req_ready", 32'(req_ready), 32'd0);
            chk("stall_flush",     32'(flush),     32'd0);
        end
        handshake(v);

        // Kill during EVAL.
        @(negedge clk);
        req_valid = 1'b1; req_funct3 = v.f3; req_rs1 = v.rs1; req_rs2 = v.rs2;
        req_pc = v.pc; req_imm = v.imm; req_pred_taken = v.pred;
        @(negedge clk);
        req_valid = 1'b0;
        kill = 1'b1;
        #1;
        chk("kill_eval_req_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        kill = 1'b0;
        #1;
        chk("kill_eval_res_valid", 32'(res_valid),   32'd0);
        chk("kill_eval_req_ready2", 32'(req_ready),  32'd1);
        chk("kill_eval_cnt_br",    cnt_branches,     exp_br);
        chk("kill_eval_cnt_mis",   cnt_mispredict,   exp_mis);

        // Kill together with res_ready in RESP: kill wins.
        to_resp(v);
        check_res(v);
        kill = 1'b1; res_ready = 1'b1;
        #1;
        chk("kill_resp_flush", 32'(flush), 32'd0);
        @(negedge clk);
        kill = 1'b0; res_ready = 1'b0;
        #1;
        chk("kill_resp_res_valid", 32'(res_valid),  32'd0);
        chk("kill_resp_req_ready", 32'(req_ready),  32'd1);
        chk("kill_resp_cnt_br",    cnt_branches,    exp_br);
        chk("kill_resp_cnt_mis",   cnt_mispredict,  exp_mis);

        // Controller recovers after kills.
        run_vec(vecs[2]);

        // Asynchronous reset while holding a wrapped-target resolution.
        v = vecs[7];
        to_resp(v);
        check_res(v);
        #2;
        rst = 1'b1;
        #1;
        exp_br = 32'd0; exp_mis = 32'd0;
        chk("arst_res_valid", 32'(res_valid),      32'd0);
        chk("arst_taken",     32'(res_taken),      32'd0);
        chk("arst_mis",       32'(res_mispredict), 32'd0);
        chk("arst_ill",       32'(res_illegal),    32'd0);
        chk("arst_target",    res_target,          32'd0);
        chk("arst_flush",     32'(flush),          32'd0);
        chk("arst_req_ready", 32'(req_ready),      32'd1);
        chk("arst_cnt_br",    cnt_branches,        exp_br);
        chk("arst_cnt_mis",   cnt_mispredict,      exp_mis);
        @(negedge clk);
        rst = 1'b0;

        run_vec(vecs[5]);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
